btn_event: RTL

Converts N debounced button/switch levels (the outputs of the per-pin debouncers) into discrete key events: single-cycle press and release pulses, a hold level after a long press, and auto-repeat pulses while held. Events are also merged into a one-entry event register with a valid/ready handshake, so the CPU-side peripheral or display logic can pop one event at a time. The block sits directly downstream of the debouncers, in the board-I/O top level.

---
 rtl/btn_event_pkg.sv | 31 +++
 rtl/btn_event_ch.sv | 120 ++++++++++++
 rtl/btn_event.sv | 113 +++++++++++
 3 files changed

// File: rtl/btn_event_pkg.sv
// ----------------------------------------------------------------------------
// btn_event_pkg
// Shared definitions for the button event block: per-channel state encoding,
// event type codes carried in evt_code[top:top-1], and the width helper used
// to size counters and the channel index field.
// ----------------------------------------------------------------------------
package btn_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_HELD    = 2'b10
    } ch_state_t;

    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;
    localparam logic [1:0] EVT_RELEASE = 2'b11;

    // Number of bits needed to hold 'value' (never less than 1).
    function automatic int get_width(input longint value);
        int w;
        w = 1;
        for (int i = 1; i < 63; i++) begin
            if ((value >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_event_ch.sv
// ----------------------------------------------------------------------------
// btn_event_ch
// One channel of the button event block. Tracks a single debounced level and
// produces registered press/release/repeat pulses plus a hold level.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   lvl        : debounced input level, synchronous to clk
//   press_o    : one-cycle pulse on a new press
//   release_o  : one-cycle pulse on release
//   hold_o     : high while held past the hold time
//   repeat_o   : one-cycle auto-repeat pulse (first one coincides with hold rise)
// ----------------------------------------------------------------------------
module btn_event_ch
    import btn_event_pkg::*;
#(
    parameter int   HOLD_CYC     = 50_000_000,
    parameter int   REP_CYC      = 10_000_000,
    parameter logic ACTIVE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lvl,
    output logic press_o,
    output logic release_o,
    output logic hold_o,
    output logic repeat_o
);

    localparam int MAX_CYC = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int CW      = get_width(longint'(MAX_CYC - 1));

    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] REP_TC  = CW'(REP_CYC - 1);

    ch_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q;
    logic          p;
    logic          press_d, release_d, hold_d, repeat_d;

    assign p = (lvl == ACTIVE_LEVEL);

    // State, counter, previous level and all pulse outputs are registered so
    // nothing downstream sees a combinational path from lvl.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            hold_o    <= 1'b0;
            repeat_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= p;
            press_o   <= press_d;
            release_o <= release_d;
            hold_o    <= hold_d;
            repeat_o  <= repeat_d;
        end
    end

    // Release is checked before the terminal count so a level drop on the
    // terminal cycle yields only a release pulse, never a repeat.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        hold_d    = hold_o;
        case (state_q)
            ST_IDLE: begin
                if (p && !prev_q) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_PRESSED: begin
                if (!p) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    hold_d    = 1'b0;
                    cnt_d     = '0;
                end else if (cnt_q == HOLD_TC) begin
                    state_d  = ST_HELD;
                    hold_d   = 1'b1;
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!p) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    hold_d    = 1'b0;
                    cnt_d     = '0;
                end else if (cnt_q == REP_TC) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/btn_event.sv
// ----------------------------------------------------------------------------
// btn_event
// Turns N debounced button levels into key events. Each channel produces
// press/release/repeat pulses and a hold level; the pulses are merged by
// fixed priority into a one-entry event register popped with valid/ready.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   lvl_i        : N debounced levels
//   press_o      : per-channel press pulse
//   release_o    : per-channel release pulse
//   hold_o       : per-channel hold level
//   repeat_o     : per-channel auto-repeat pulse
//   evt_valid    : event register occupied
//   evt_code     : {type[1:0], channel index}
//   evt_ready    : consumer pops the event
//   evt_overflow : sticky, some pulse was not captured
// ----------------------------------------------------------------------------
module btn_event
    import btn_event_pkg::*;
#(
    parameter int   N            = 5,
    parameter int   CLK_FREQ     = 100,
    parameter int   HOLD_US      = 500_000,
    parameter int   REPEAT_US    = 100_000,
    parameter logic ACTIVE_LEVEL = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N-1:0]                         lvl_i,
    output logic [N-1:0]                         press_o,
    output logic [N-1:0]                         release_o,
    output logic [N-1:0]                         hold_o,
    output logic [N-1:0]                         repeat_o,
    output logic                                 evt_valid,
    output logic [2+get_width(longint'(N-1))-1:0] evt_code,
    input  logic                                 evt_ready,
    output logic                                 evt_overflow
);

    localparam int W        = get_width(longint'(N - 1));
    localparam int HOLD_CYC = CLK_FREQ * HOLD_US;
    localparam int REP_CYC  = CLK_FREQ * REPEAT_US;

    logic [N-1:0]   any_pulse;
    logic           cand_valid;
    logic [W+1:0]   cand_code;
    logic           multi_pulse;
    logic           load;
    logic           pop;

    for (genvar i = 0; i < N; i++) begin : gen_ch
        btn_event_ch #(
            .HOLD_CYC     (HOLD_CYC),
            .REP_CYC      (REP_CYC),
            .ACTIVE_LEVEL (ACTIVE_LEVEL)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .lvl       (lvl_i[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i]),
            .hold_o    (hold_o[i]),
            .repeat_o  (repeat_o[i])
        );
    end

    assign any_pulse = press_o | release_o | repeat_o;

    // Scanning from the top down lets the lowest active index win.
    always_comb begin
        cand_valid = 1'b0;
        cand_code  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (any_pulse[i]) begin
                cand_valid = 1'b1;
                if (press_o[i]) begin
                    cand_code = {EVT_PRESS, W'(i)};
                end else if (release_o[i]) begin
                    cand_code = {EVT_RELEASE, W'(i)};
                end else begin
                    cand_code = {EVT_REPEAT, W'(i)};
                end
            end
        end
    end

    // More than one channel pulsing means all but the winner are lost.
    assign multi_pulse = |(any_pulse & (any_pulse - 1'b1));
    assign pop         = evt_valid & evt_ready;
    assign load        = cand_valid & (~evt_valid | evt_ready);

    // Event register and sticky overflow; a pop and a new load may share a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid    <= 1'b0;
            evt_code     <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (load) begin
                evt_valid <= 1'b1;
                evt_code  <= cand_code;
            end else if (pop) begin
                evt_valid <= 1'b0;
            end
            if (multi_pulse || (cand_valid && !load)) begin
                evt_overflow <= 1'b1;
            end
        end
    end

endmodule
